id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RISC-V pipeline. It sits directly downstream of the opcode control decoder and the register file. It captures the decoded control bits, operands and register indices each cycle and presents them to the EX stage. It also contains load-use hazard detection, which inserts bubbles and stalls IF/ID. A saturating counter records the number of hazard bubbles inserted.

Parameters:
XLEN, 32, datapath width of pc, operands and immediate
CNT_W, 16, width of the hazard-bubble performance counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  input  1 each  decoded control bits
id_alu_op  input  2  decoded ALU op class
id_pc  input  XLEN  instruction PC
id_rs1_data, id_rs2_data  input  XLEN  register-file read data
id_imm  input  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  input  5 each  register indices
id_funct3  input  3  instr[14:12]
id_funct7b5  input  1  instr[30]
flush  input  1  branch taken in EX; kill the instruction entering EX
ex_hold  input  1  EX cannot accept a new instruction this cycle
ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  output  1 each  registered copies
ex_alu_op  output  2  registered
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered
ex_rs1, ex_rs2, ex_rd  output  5 each  registered
ex_funct3  output  3  registered
ex_funct7b5  output  1  registered
stall  output  1  combinational; IF/ID register and PC must hold
bubble_cnt  output  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Reset (rst=1 at clock edge): every registered output is 0, including bubble_cnt. The stage holds a bubble after reset.
- Latency: one cycle. Inputs sampled at edge N appear on ex_* after edge N.
- Bubble definition: ex_valid and all seven control bits are 0, and ex_alu_op is 0. Data and index fields are don't-care; the implementation zeroes them.
- Hazard: hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2))).
- uses_rs2 = ~id_alu_src | id_mem_write. This covers R-type, branch and store.
- Priority per cycle, highest first:
  1. rst: reset as above.
  2. flush: load a bubble; stall = 0; counter unchanged. Flush overrides both ex_hold and hz.
  3. ex_hold: all ex_* registers keep their values; stall = 1; counter unchanged.
  4. hz: load a bubble; stall = 1; bubble_cnt increments unless it equals all-ones.
  5. Otherwise: load the id_* fields with ex_valid = id_valid; stall = 0.
- If id_valid = 0 in the normal case, load a bubble regardless of the id_* control bits.
- stall is a pure function of the current registered state and the current inputs. Formula: stall = ~flush & (ex_hold | hz). Reset does not gate it.
- After hz, the held ID instruction re-evaluates the next cycle. ex_mem_read is then 0, so it proceeds. Exactly one bubble is inserted per load-use pair.
- rd = x0 never causes a hazard.
- bubble_cnt saturates at 2^CNT_W - 1 and never wraps.
- Reset asserted mid-stall clears all state. stall in the following cycle depends only on the inputs.

Test Plan:
- Reset: drive rst=1 for 2 cycles with id_valid=1 and all control inputs high → ex_valid=0, all ex_* outputs 0, bubble_cnt=0, stall=0.
- Pass-through: R-type with id_reg_write=1, alu_op=2'b10, rs1=3, rs2=4, rd=5, pc=0x40 → next cycle ex_* match exactly, stall=0.
- Load-use: load rd=5, then add rs2=5 (alu_src=0) → stall=1 for one cycle, one bubble, bubble_cnt=1, then add passes. Same sequence with an I-type using only rs1=6 → no stall.
- x0 and store: load rd=0 followed by a use of x0 → no stall. Load rd=7 then store rs2=7 → stall.
- Flush vs hold: assert flush and ex_hold together with a hazard present → bubble loaded, stall=0, bubble_cnt unchanged. ex_hold alone for 3 cycles → ex_* frozen, stall=1.
- Saturation: CNT_W=2, four consecutive load-use pairs → bubble_cnt reads 1,2,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// counter of inserted hazard bubbles.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [1:0]       id_alu_op,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,

    input  logic             flush,
    input  logic             ex_hold,

    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic [1:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,

    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned F3_W    = 3;

    // Everything that travels from ID into EX; an all-zero value is a bubble.
    typedef struct packed {
        logic               valid;
        logic               branch;
        logic               mem_read;
        logic               mem_to_reg;
        logic               mem_write;
        logic               alu_src;
        logic               reg_write;
        logic [ALUOP_W-1:0] alu_op;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic [F3_W-1:0]    funct3;
        logic               funct7b5;
    } ex_pkt_t;

    ex_pkt_t          ex_q;
    ex_pkt_t          ex_d;
    ex_pkt_t          id_pkt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             uses_rs2;
    logic             hz;

    // Pack the incoming ID fields into one payload.
    always_comb begin
        id_pkt            = '0;
        id_pkt.valid      = 1'b1;
        id_pkt.branch     = id_branch;
        id_pkt.mem_read   = id_mem_read;
        id_pkt.mem_to_reg = id_mem_to_reg;
        id_pkt.mem_write  = id_mem_write;
        id_pkt.alu_src    = id_alu_src;
        id_pkt.reg_write  = id_reg_write;
        id_pkt.alu_op     = id_alu_op;
        id_pkt.pc         = id_pc;
        id_pkt.rs1_data   = id_rs1_data;
        id_pkt.rs2_data   = id_rs2_data;
        id_pkt.imm        = id_imm;
        id_pkt.rs1        = id_rs1;
        id_pkt.rs2        = id_rs2;
        id_pkt.rd         = id_rd;
        id_pkt.funct3     = id_funct3;
        id_pkt.funct7b5   = id_funct7b5;
    end

    // Load-use detection: a load in EX whose rd feeds the instruction in ID.
    always_comb begin
        uses_rs2 = ~id_alu_src | id_mem_write;
        hz       = id_valid & ex_q.valid & ex_q.mem_read
                 & (ex_q.rd != REG_W'(0))
                 & ((ex_q.rd == id_rs1) | (uses_rs2 & (ex_q.rd == id_rs2)));
        stall    = ~flush & (ex_hold | hz);
    end

    // Next-state selection: flush > hold > hazard bubble > normal capture.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_hold) begin
            ex_d = ex_q;
        end else if (hz) begin
            ex_d = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (id_valid) begin
            ex_d = id_pkt;
        end else begin
            ex_d = '0;
        end
    end

    // Pipeline register and counter, synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_branch     = ex_q.branch;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7b5   = ex_q.funct7b5;
    assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Vector-table bench for id_ex_stage; expected EX contents are queued at drive
// time and compared after the capturing edge. A second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_id_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
    logic        id_alu_src, id_reg_write, id_funct7b5, flush, ex_hold;
    logic [1:0]  id_alu_op;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;

    logic        a_valid, a_branch, a_mem_read, a_mem_to_reg, a_mem_write, a_alu_src, a_reg_write, a_f7, a_stall;
    logic [1:0]  a_alu_op;
    logic [31:0] a_pc, a_rs1d, a_rs2d, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [15:0] a_cnt;

    logic        b_valid, b_branch, b_mem_read, b_mem_to_reg, b_mem_write, b_alu_src, b_reg_write, b_f7, b_stall;
    logic [1:0]  b_alu_op;
    logic [31:0] b_pc, b_rs1d, b_rs2d, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_f3;
    logic [1:0]  b_cnt;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(a_valid), .ex_branch(a_branch), .ex_mem_read(a_mem_read),
        .ex_mem_to_reg(a_mem_to_reg), .ex_mem_write(a_mem_write), .ex_alu_src(a_alu_src),
        .ex_reg_write(a_reg_write), .ex_alu_op(a_alu_op), .ex_pc(a_pc),
        .ex_rs1_data(a_rs1d), .ex_rs2_data(a_rs2d), .ex_imm(a_imm), .ex_rs1(a_rs1),
        .ex_rs2(a_rs2), .ex_rd(a_rd), .ex_funct3(a_f3), .ex_funct7b5(a_f7),
        .stall(a_stall), .bubble_cnt(a_cnt)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(b_valid), .ex_branch(b_branch), .ex_mem_read(b_mem_read),
        .ex_mem_to_reg(b_mem_to_reg), .ex_mem_write(b_mem_write), .ex_alu_src(b_alu_src),
        .ex_reg_write(b_reg_write), .ex_alu_op(b_alu_op), .ex_pc(b_pc),
        .ex_rs1_data(b_rs1d), .ex_rs2_data(b_rs2d), .ex_imm(b_imm), .ex_rs1(b_rs1),
        .ex_rs2(b_rs2), .ex_rd(b_rd), .ex_funct3(b_f3), .ex_funct7b5(b_f7),
        .stall(b_stall), .bubble_cnt(b_cnt)
    );

    // Control field order: {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
    localparam logic [5:0] C_R   = 6'b000001;
    localparam logic [5:0] C_LD  = 6'b011011;
    localparam logic [5:0] C_I   = 6'b000011;
    localparam logic [5:0] C_ST  = 6'b000110;
    localparam logic [5:0] C_ALL = 6'b111111;

    typedef enum logic [1:0] {K_BUB, K_PASS, K_KEEP} kind_e;

    typedef struct {
        logic        rst, flush, hold, valid;
        logic [5:0]  ctl;
        logic [1:0]  alu_op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc;
        logic        chk_stall, exp_stall;
        kind_e       kind;
        logic [15:0] c16;
        logic [1:0]  c2;
    } vec_t;

    typedef struct packed {
        logic        valid, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
        logic [1:0]  alu_op;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } ex_t;

    typedef struct {
        ex_t         ex;
        logic [15:0] c16;
        logic [1:0]  c2;
        int          row;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic vec_t mk(logic r, logic f, logic h, logic v, logic [5:0] c, logic [1:0] op,
                                logic [4:0] s1, logic [4:0] s2, logic [4:0] d, logic [31:0] pc,
                                logic cs, logic es, kind_e k, logic [15:0] c16, logic [1:0] c2);
        vec_t t;
        t.rst = r; t.flush = f; t.hold = h; t.valid = v; t.ctl = c; t.alu_op = op;
        t.rs1 = s1; t.rs2 = s2; t.rd = d; t.pc = pc;
        t.chk_stall = cs; t.exp_stall = es; t.kind = k; t.c16 = c16; t.c2 = c2;
        return t;
    endfunction

    // Operand data is derived from the PC so every field is distinctive.
    function automatic ex_t pass_of(vec_t t);
        ex_t e;
        e.valid = 1'b1;
        {e.branch, e.mem_read, e.mem_to_reg, e.mem_write, e.alu_src, e.reg_write} = t.ctl;
        e.alu_op = t.alu_op; e.pc = t.pc;
        e.rs1d = t.pc ^ 32'h1111_0000; e.rs2d = t.pc ^ 32'h2222_0000; e.imm = ~t.pc;
        e.rs1 = t.rs1; e.rs2 = t.rs2; e.rd = t.rd; e.f3 = t.pc[4:2]; e.f7 = t.pc[2];
        return e;
    endfunction

    task automatic drive(vec_t t);
        ex_t e;
        e = pass_of(t);
        rst = t.rst; flush = t.flush; ex_hold = t.hold; id_valid = t.valid;
        {id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = t.ctl;
        id_alu_op = t.alu_op; id_pc = t.pc; id_rs1_data = e.rs1d; id_rs2_data = e.rs2d;
        id_imm = e.imm; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        id_funct3 = e.f3; id_funct7b5 = e.f7;
    endtask

    task automatic check_ex(string name, int row, ex_t act, ex_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s row%0d: got %h want %h", name, row, act, exp);
        end
    endtask

    initial begin
        ex_t  prev;
        ex_t  exp;
        ex_t  act_a;
        ex_t  act_b;
        sb_t  item;
        logic [4:0] lrd;

        // rst cycles with every control input high
        vecs.push_back(mk(1,0,0,1,C_ALL,2'b11, 5, 5, 5,32'h3c, 0,0,K_BUB, 0,0));
        vecs.push_back(mk(1,0,0,1,C_ALL,2'b11, 5, 5, 5,32'h3c, 1,0,K_BUB, 0,0));
        // pass-through and load-use on rs2
        vecs.push_back(mk(0,0,0,1,C_R,  2'b10, 3, 4, 5,32'h40, 1,0,K_PASS,0,0));
        vecs.push_back(mk(0,0,0,1,C_LD, 2'b00, 1, 0, 5,32'h44, 1,0,K_PASS,0,0));
        vecs.push_back(mk(0,0,0,1,C_R,  2'b10, 2, 5, 8,32'h48, 1,1,K_BUB, 1,1));
        vecs.push_back(mk(0,0,0,1,C_R,  2'b10, 2, 5, 8,32'h48, 1,0,K_PASS,1,1));
        // I-type reading only rs1: rs2 field matching the load rd must not stall
        vecs.push_back(mk(0,0,0,1,C_LD, 2'b00, 1, 0, 5,32'h4c, 1,0,K_PASS,1,1));
        vecs.push_back(mk(0,0,0,1,C_I,  2'b10, 6, 5, 9,32'h50, 1,0,K_PASS,1,1));
        // load to x0 never stalls
        vecs.push_back(mk(0,0,0,1,C_LD, 2'b00, 1, 0, 0,32'h54, 1,0,K_PASS,1,1));
        vecs.push_back(mk(0,0,0,1,C_R,  2'b10, 0, 0,10,32'h58, 1,0,K_PASS,1,1));
        // store data register depends on load
        vecs.push_back(mk(0,0,0,1,C_LD, 2'b00, 1, 0, 7,32'h5c, 1,0,K_PASS,1,1));
        vecs.push_back(mk(0,0,0,1,C_ST, 2'b00, 2, 7, 0,32'h60, 1,1,K_BUB, 2,2));
        vecs.push_back(mk(0,0,0,1,C_ST, 2'b00, 2, 7, 0,32'h60, 1,0,K_PASS,2,2));
        // flush with hold and a live hazard
        vecs.push_back(mk(0,0,0,1,C_LD, 2'b00, 1, 0, 5,32'h64, 1,0,K_PASS,2,2));
        vecs.push_back(mk(0,1,1,1,C_R,  2'b10, 5, 5,11,32'h68, 1,0,K_BUB, 2,2));
        // hold for three cycles freezes EX
        vecs.push_back(mk(0,0,0,1,C_R,  2'b10, 1, 2,11,32'h6c, 1,0,K_PASS,2,2));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,1,1,C_LD,2'b00,11, 0,12,32'h70, 1,1,K_KEEP,2,2));
        vecs.push_back(mk(0,0,0,1,C_LD, 2'b00,11, 0,12,32'h70, 1,0,K_PASS,2,2));
        // id_valid low yields a bubble despite control bits
        vecs.push_back(mk(0,0,0,0,C_ALL,2'b11,12,12,12,32'h74, 1,0,K_BUB, 2,2));
        // reset during a hazard: stall still follows the inputs
        vecs.push_back(mk(0,0,0,1,C_LD, 2'b00, 1, 0,13,32'h78, 1,0,K_PASS,2,2));
        vecs.push_back(mk(1,0,0,1,C_R,  2'b10,13, 0,14,32'h7c, 1,1,K_BUB, 0,0));
        vecs.push_back(mk(0,0,0,1,C_R,  2'b10,13, 0,14,32'h7c, 1,0,K_PASS,0,0));
        // four load-use pairs: 2-bit counter saturates at 3
        for (int p = 0; p < 4; p++) begin
            lrd = 5'(15 + p);
            vecs.push_back(mk(0,0,0,1,C_LD,2'b00,1,0,lrd,32'h80 + 32'(p*16), 1,0,K_PASS,16'(p),2'(p)));
            vecs.push_back(mk(0,0,0,1,C_R, 2'b10,lrd,3,20,32'h84 + 32'(p*16), 1,1,K_BUB,16'(p+1),
                              (p >= 2) ? 2'd3 : 2'(p+1)));
            vecs.push_back(mk(0,0,0,1,C_R, 2'b10,lrd,3,20,32'h84 + 32'(p*16), 1,0,K_PASS,16'(p+1),
                              (p >= 2) ? 2'd3 : 2'(p+1)));
        end

        prev = '0;
        @(negedge clk);
        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r]);
            case (vecs[r].kind)
                K_PASS:  exp = pass_of(vecs[r]);
                K_KEEP:  exp = prev;
                default: exp = '0;
            endcase
            prev = exp;
            item.ex = exp; item.c16 = vecs[r].c16; item.c2 = vecs[r].c2; item.row = r;
            sb.push_back(item);
            #1;
            if (vecs[r].chk_stall) begin
                tests_run++;
                if (a_stall !== vecs[r].exp_stall || b_stall !== vecs[r].exp_stall) begin
                    tests_failed++;
                    $display("FAIL stall row%0d: got %b/%b want %b", r, a_stall, b_stall, vecs[r].exp_stall);
                end
            end
            @(posedge clk);
            #1;
            item = sb.pop_front();
            act_a = {a_valid, a_branch, a_mem_read, a_mem_to_reg, a_mem_write, a_alu_src, a_reg_write,
                     a_alu_op, a_pc, a_rs1d, a_rs2d, a_imm, a_rs1, a_rs2, a_rd, a_f3, a_f7};
            act_b = {b_valid, b_branch, b_mem_read, b_mem_to_reg, b_mem_write, b_alu_src, b_reg_write,
                     b_alu_op, b_pc, b_rs1d, b_rs2d, b_imm, b_rs1, b_rs2, b_rd, b_f3, b_f7};
            check_ex("ex_fields", item.row, act_a, item.ex);
            check_ex("ex_fields_sat", item.row, act_b, item.ex);
            tests_run++;
            if (a_cnt !== item.c16) begin
                tests_failed++;
                $display("FAIL bubble_cnt row%0d: got %0d want %0d", item.row, a_cnt, item.c16);
            end
            tests_run++;
            if (b_cnt !== item.c2) begin
                tests_failed++;
                $display("FAIL bubble_cnt_sat row%0d: got %0d want %0d", item.row, b_cnt, item.c2);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
